// File: rtl/nibble_demux_4_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_demux_4_if
// Purpose  : Bus bundle for the nibble_demux_4 receive path. Carries the
//            time-multiplexed slot stream into the demux and the committed
//            frame registers plus status pulses back out.
// Ports    : in_valid/in_sof/in_data  - slot stream (master -> slave)
//            out_a..out_d             - committed slots 0..3 (slave -> master)
//            frame_done/frame_err     - one-cycle status pulses
//            busy                     - frame collection in progress
//            err_count                - saturating error count, present only
//                                       when NIBBLE_DEMUX_ERRCNT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_demux_4_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic             frame_done;
    logic             frame_err;
    logic             busy;
`ifdef NIBBLE_DEMUX_ERRCNT_EN
    logic [7:0]       err_count;
`endif

    // Source side: drives the stream, observes the committed frame.
    modport master (
        output in_valid, in_sof, in_data,
        input  out_a, out_b, out_c, out_d, frame_done, frame_err, busy
`ifdef NIBBLE_DEMUX_ERRCNT_EN
        , input err_count
`endif
    );

    // Demux side.
    modport slave (
        input  in_valid, in_sof, in_data,
        output out_a, out_b, out_c, out_d, frame_done, frame_err, busy
`ifdef NIBBLE_DEMUX_ERRCNT_EN
        , output err_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/nibble_demux_4.sv
`default_nettype none
// ============================================================================
// Module   : nibble_demux_4
// Purpose  : Receive end of a 4-way nibble multiplexing path. Collects slots
//            0..3 of a frame into a shadow buffer and commits all four output
//            registers in one edge, so consumers never see a mixed frame.
//            Stray beats, early SOF and mid-frame stalls raise frame_err and
//            discard the partial frame.
// Ports    : clk   - system clock, rising edge
//            reset - synchronous, active-high
//            bus   - nibble_demux_4_if.slave (stream in, frame/status out)
// Params   : WIDTH          - slot word width
//            TIMEOUT_CYCLES - idle cycles tolerated mid-frame (2..65535)
// Options  : NIBBLE_DEMUX_ERRCNT_EN - adds bus.err_count, a saturating count
//            of frame_err pulses
// Revision : 1.0 - initial release
// ============================================================================
module nibble_demux_4 #(
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    nibble_demux_4_if.slave bus
);
    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_COLLECT = 1'b1;
    // The abort fires on the edge that would make the idle count reach
    // TIMEOUT_CYCLES, so compare against one less.
    localparam logic [15:0] C_IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [15:0]      idle_q, idle_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] shadow2_q, shadow2_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        idle_d    = idle_q;
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        out_c_d   = out_c_q;
        out_d_d   = out_d_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_sof) begin
                        shadow0_d = bus.in_data;
                        slot_d    = 2'd1;
                        idle_d    = 16'd0;
                        state_d   = ST_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.in_valid) begin
                    idle_d = 16'd0;
                    if (bus.in_sof) begin
                        // Early SOF: drop the partial frame, restart at slot 0.
                        err_d     = 1'b1;
                        shadow0_d = bus.in_data;
                        slot_d    = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        // Slot 3 bypasses the shadow so the commit needs no
                        // extra cycle and back-to-back frames have no bubble.
                        out_a_d = shadow0_q;
                        out_b_d = shadow1_q;
                        out_c_d = shadow2_q;
                        out_d_d = bus.in_data;
                        done_d  = 1'b1;
                        slot_d  = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        case (slot_q)
                            2'd1:    shadow1_d = bus.in_data;
                            2'd2:    shadow2_d = bus.in_data;
                            default: shadow0_d = bus.in_data;
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end else if (idle_q == C_IDLE_LAST) begin
                    err_d   = 1'b1;
                    idle_d  = 16'd0;
                    slot_d  = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= 2'd0;
            idle_q    <= 16'd0;
            shadow0_q <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_c_q   <= '0;
            out_d_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            idle_q    <= idle_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            out_c_q   <= out_c_d;
            out_d_q   <= out_d_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.out_a      = out_a_q;
    assign bus.out_b      = out_b_q;
    assign bus.out_c      = out_c_q;
    assign bus.out_d      = out_d_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = (state_q == ST_COLLECT);

`ifdef NIBBLE_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Updated on the same edge that raises frame_err, so the count already
    // includes the pulse that is currently visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
`endif
endmodule
`default_nettype wire

// File: tb/tb_nibble_demux_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_demux_4
// Purpose  : Self-checking bench for nibble_demux_4 (TIMEOUT_CYCLES = 4).
//            One table row per clock: inputs applied before the edge and the
//            registered outputs expected just after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_demux_4;
    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    nibble_demux_4_if #(.WIDTH(WIDTH)) bus ();

    nibble_demux_4 #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic       s;
        logic [3:0] d;
        logic [3:0] ea, eb, ec, ed;
        logic       done, err, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic s,
                                input logic [3:0] d, input logic [3:0] ea,
                                input logic [3:0] eb, input logic [3:0] ec,
                                input logic [3:0] ed, input logic done,
                                input logic err, input logic busy);
        vec_t r;
        r.rst = rst; r.v = v; r.s = s; r.d = d;
        r.ea = ea; r.eb = eb; r.ec = ec; r.ed = ed;
        r.done = done; r.err = err; r.busy = busy;
        return r;
    endfunction

    task automatic step(input logic rst, input logic v, input logic s,
                        input logic [3:0] d);
        reset        = rst;
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bits(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {13'd0, bus.out_a, bus.out_b, bus.out_c, bus.out_d,
                bus.frame_done, bus.frame_err, bus.busy};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_err;
        int waited;
        checks = 0;
        errors = 0;
        reset = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;

        //                 rst v s d      a    b    c    d   dn er by
        vecs.push_back(mk(1,0,0,4'h0, 4'h0,4'h0,4'h0,4'h0, 0,0,0)); // reset
        vecs.push_back(mk(0,0,0,4'h0, 4'h0,4'h0,4'h0,4'h0, 0,0,0));
        // Basic frame 3,2,1,F
        vecs.push_back(mk(0,1,1,4'h3, 4'h0,4'h0,4'h0,4'h0, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h2, 4'h0,4'h0,4'h0,4'h0, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h1, 4'h0,4'h0,4'h0,4'h0, 0,0,1));
        vecs.push_back(mk(0,1,0,4'hF, 4'h3,4'h2,4'h1,4'hF, 1,0,0));
        vecs.push_back(mk(0,0,0,4'h0, 4'h3,4'h2,4'h1,4'hF, 0,0,0));
        // Back-to-back 1,2,3,4 then 5,6,7,8
        vecs.push_back(mk(0,1,1,4'h1, 4'h3,4'h2,4'h1,4'hF, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h2, 4'h3,4'h2,4'h1,4'hF, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h3, 4'h3,4'h2,4'h1,4'hF, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h4, 4'h1,4'h2,4'h3,4'h4, 1,0,0));
        vecs.push_back(mk(0,1,1,4'h5, 4'h1,4'h2,4'h3,4'h4, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h6, 4'h1,4'h2,4'h3,4'h4, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h7, 4'h1,4'h2,4'h3,4'h4, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h8, 4'h5,4'h6,4'h7,4'h8, 1,0,0));
        vecs.push_back(mk(0,0,0,4'h0, 4'h5,4'h6,4'h7,4'h8, 0,0,0));
        // Early SOF: 9,8 then SOF A,B,C,D
        vecs.push_back(mk(0,1,1,4'h9, 4'h5,4'h6,4'h7,4'h8, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h8, 4'h5,4'h6,4'h7,4'h8, 0,0,1));
        vecs.push_back(mk(0,1,1,4'hA, 4'h5,4'h6,4'h7,4'h8, 0,1,1));
        vecs.push_back(mk(0,1,0,4'hB, 4'h5,4'h6,4'h7,4'h8, 0,0,1));
        vecs.push_back(mk(0,1,0,4'hC, 4'h5,4'h6,4'h7,4'h8, 0,0,1));
        vecs.push_back(mk(0,1,0,4'hD, 4'hA,4'hB,4'hC,4'hD, 1,0,0));
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,0,0));
        // Timeout: SOF 7 then 4 idle cycles
        vecs.push_back(mk(0,1,1,4'h7, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,1,0));
        vecs.push_back(mk(0,1,0,4'h5, 4'hA,4'hB,4'hC,4'hD, 0,1,0)); // stray
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'hB,4'hC,4'hD, 0,0,0));
        // Reset after slot 2, then frame 1,1,1,1
        vecs.push_back(mk(0,1,1,4'h2, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h3, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h4, 4'hA,4'hB,4'hC,4'hD, 0,0,1));
        vecs.push_back(mk(1,0,0,4'h0, 4'h0,4'h0,4'h0,4'h0, 0,0,0));
        vecs.push_back(mk(0,1,1,4'h1, 4'h0,4'h0,4'h0,4'h0, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h1, 4'h0,4'h0,4'h0,4'h0, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h1, 4'h0,4'h0,4'h0,4'h0, 0,0,1));
        vecs.push_back(mk(0,1,0,4'h1, 4'h1,4'h1,4'h1,4'h1, 1,0,0));
        vecs.push_back(mk(0,0,0,4'h0, 4'h1,4'h1,4'h1,4'h1, 0,0,0));
        // Two consecutive strays: one pulse per beat
        vecs.push_back(mk(0,1,0,4'h6, 4'h1,4'h1,4'h1,4'h1, 0,1,0));
        vecs.push_back(mk(0,1,0,4'h7, 4'h1,4'h1,4'h1,4'h1, 0,1,0));
        vecs.push_back(mk(0,0,0,4'h0, 4'h1,4'h1,4'h1,4'h1, 0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] exp;
            step(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].d);
            exp = {13'd0, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed,
                   vecs[i].done, vecs[i].err, vecs[i].busy};
            check_bits($sformatf("vec%0d", i), snap(), exp);
        end

        // Gaps of 3 idle cycles between beats stay below the timeout,
        // because each beat clears the idle count.
        saw_err = 0;
        step(0, 1, 1, 4'h9);
        for (int b = 0; b < 3; b++) begin
            for (int g = 0; g < 3; g++) begin
                step(0, 0, 0, 4'h0);
                if (bus.frame_err) saw_err++;
            end
            step(0, 1, 0, 4'(4'hA + b));
            if (bus.frame_err) saw_err++;
        end
        check_bits("gap_no_err", 32'(saw_err), 32'd0);
        check_bits("gap_done", {31'd0, bus.frame_done}, 32'd1);
        check_bits("gap_outs", {16'd0, bus.out_a, bus.out_b, bus.out_c, bus.out_d},
                   32'h9ABC);

        // Long idle in IDLE must not disturb anything; bounded wait.
        waited = 0;
        while (waited < 20) begin
            step(0, 0, 0, 4'h0);
            if (bus.frame_err || bus.frame_done || bus.busy) break;
            waited++;
        end
        check_bits("idle_quiet", 32'(waited), 32'd20);

`ifdef NIBBLE_DEMUX_ERRCNT_EN
        step(1, 0, 0, 4'h0);
        check_bits("errcnt_reset", 32'(bus.err_count), 32'd0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 4'h3);
        check_bits("errcnt_10", 32'(bus.err_count), 32'd10);
        for (int k = 10; k < 300; k++) step(0, 1, 0, 4'h3);
        check_bits("errcnt_sat", 32'(bus.err_count), 32'd255);
        step(1, 0, 0, 4'h0);
        check_bits("errcnt_clr", 32'(bus.err_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nibble_demux_4.md
Name: nibble_demux_4

Overview:
- Receive end of the 4-way nibble multiplexing path: accepts a time-multiplexed stream of WIDTH-bit words (slot 0..3, slot 0 flagged by in_sof) and reassembles them into four parallel output registers out_a..out_d.
- Frames commit atomically through a shadow buffer, so downstream logic (display/compare stages) never sees a partially updated set.
- Framing errors and stalls are detected, flagged and discarded.

Parameters:
- WIDTH, 4, bit width of each slot word and each output register.
- TIMEOUT_CYCLES, 1000, consecutive idle cycles allowed mid-frame before abort; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  beat qualifier; block is always ready, every valid beat is consumed.
- in_sof  input  1  start of frame; marks the beat as slot 0.
- in_data  input  WIDTH  slot word.
- out_a  output  WIDTH  committed slot 0.
- out_b  output  WIDTH  committed slot 1.
- out_c  output  WIDTH  committed slot 2.
- out_d  output  WIDTH  committed slot 3.
- frame_done  output  1  one-cycle pulse, new frame committed.
- frame_err  output  1  one-cycle pulse, frame aborted or stray beat dropped.
- busy  output  1  high while in COLLECT.

Behaviour:
- All outputs registered. Reset (sampled on clk edge) clears out_a..out_d, shadow regs, slot counter and idle counter to 0; frame_done=0, frame_err=0, busy=0; state=IDLE. Reset mid-frame discards the partial frame with no pulse.
- States: IDLE, COLLECT. busy = (state==COLLECT).
- IDLE:
  - in_valid&in_sof: shadow[0]<=in_data, slot<=1, ->COLLECT.
  - in_valid&!in_sof: beat dropped, frame_err pulse, stay IDLE.
  - no valid: hold.
- COLLECT:
  - in_valid&!in_sof, slot<3: shadow[slot]<=in_data, slot++; idle counter cleared.
  - in_valid&!in_sof, slot==3: out_a..c<=shadow[0..2], out_d<=in_data at the same edge; frame_done=1 next cycle; ->IDLE.
  - in_valid&in_sof (early SOF): frame_err pulse, partial frame discarded, beat taken as new slot 0 (shadow[0]<=in_data, slot<=1), stay COLLECT.
  - no valid: idle counter++. On reaching TIMEOUT_CYCLES: frame_err pulse, ->IDLE, outputs unchanged.
- Latency: new out_* values and frame_done become visible in the cycle after the slot-3 beat. Back-to-back frames (SOF in the cycle after slot 3) are accepted with no bubble.
- frame_done and frame_err are never asserted together. Each is high for exactly one cycle per event.
- out_* change only on commit or reset.
- Slot counter is 2 bits. It never wraps inside a frame because a frame ends at slot 3.

Optional Feature:
- Macro NIBBLE_DEMUX_ERRCNT_EN.
- Defined: adds output port err_count [7:0], a saturating count of frame_err pulses (sticks at 255). Cleared by reset. Increments in the same cycle frame_err is asserted.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Reset then beats (sof,3),(2),(1),(0xF) on consecutive cycles -> one cycle after the last beat: out_a=3, out_b=2, out_c=1, out_d=F, frame_done=1 for one cycle; busy falls the same cycle.
- Two back-to-back frames 1,2,3,4 then 5,6,7,8 with no gap -> two frame_done pulses 4 cycles apart; final outputs 5,6,7,8; no frame_err.
- Frame 9,8 then SOF with A, then B,C,D -> frame_err pulse on the cycle after the SOF beat; then commit A,B,C,D; out_* never show 9 or 8.
- TIMEOUT_CYCLES=4: SOF 7, then in_valid low for 4 cycles -> frame_err pulse; busy=0; outputs keep previous frame; a later non-SOF beat gives another frame_err.
- Reset asserted after slot 2 of a frame, then a full frame 1,1,1,1 -> no pulse from the aborted frame; outputs go 0 then 1,1,1,1 with frame_done.
- With NIBBLE_DEMUX_ERRCNT_EN: 300 stray non-SOF beats in IDLE -> err_count=255 (saturated); reset -> 0.
